// File: rtl/mux_rr_arbiter.sv
// Two-source round-robin arbiter driving a 2:1 mux select.
// The granted word is captured into a one-entry output register
// with its own valid/ready handshake. On a tie, the source that
// was not granted last time wins. A lone requester is served
// every cycle.
module mux_rr_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D0,
  input  logic             V0,
  output logic             R0,
  input  logic [WIDTH-1:0] D1,
  input  logic             V1,
  output logic             R1,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             YV,
  input  logic             YR
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t state;
  logic   last;
  logic   grant_any;
  logic   grant_idx;
  logic   open;
  logic   accept;

  // Pick a source. A tie goes to the one not granted last. With no
  // request, the select parks on the last grant so the mux does not
  // toggle for nothing.
  always_comb begin
    grant_any = V0 | V1;
    grant_idx = V1;
    if (V0 && V1) begin
      grant_idx = ~last;
    end
    S      = grant_any ? grant_idx : last;
    open   = ~YV | YR;
    R0     = ~rst & open & V0 & ~grant_idx;
    R1     = ~rst & open & V1 & grant_idx;
    accept = R0 | R1;
  end

  // Output register FSM. An accept loads a new word, even when the
  // old word drains in the same cycle, so no bubble is inserted.
  // A drain without an accept empties the register. Y itself keeps
  // its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      YV    <= 1'b0;
      Y     <= '0;
      last  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
            YV    <= 1'b1;
            Y     <= S ? D1 : D0;
            last  <= S;
          end
        end
        FULL: begin
          if (accept) begin
            state <= FULL;
            YV    <= 1'b1;
            Y     <= S ? D1 : D0;
            last  <= S;
          end else if (YR) begin
            state <= EMPTY;
            YV    <= 1'b0;
          end
        end
        default: begin
          state <= EMPTY;
          YV    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter.
// Runs directed scenarios with literal expectations, then random
// traffic. A cycle-level reference model is compared on every
// falling edge.
module tb_mux_rr_arbiter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] D0;
  logic         V0;
  logic         R0;
  logic [W-1:0] D1;
  logic         V1;
  logic         R1;
  logic         S;
  logic [W-1:0] Y;
  logic         YV;
  logic         YR;

  int total = 0;
  int bad   = 0;

  // Reference model state: the output register contents and the
  // most recent grant.
  logic         model_ok = 1'b0;
  logic [W-1:0] m_y;
  logic         m_yv;
  int           m_last;

  mux_rr_arbiter #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .D0(D0),
    .V0(V0),
    .R0(R0),
    .D1(D1),
    .V1(V1),
    .R1(R1),
    .S(S),
    .Y(Y),
    .YV(YV),
    .YR(YR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record one comparison; print a line if it does not match.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive the inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic r, input logic v0, input logic v1,
                               input logic [W-1:0] d0, input logic [W-1:0] d1,
                               input logic yr);
    rst = r;
    V0  = v0;
    V1  = v1;
    D0  = d0;
    D1  = d1;
    YR  = yr;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare against the model each cycle. The model is then advanced
  // using the inputs that will be present at the coming rising edge.
  always @(negedge clk) begin
    int  pick;
    bit  room;
    bit  take;
    logic [W-1:0] e_r0;
    logic [W-1:0] e_r1;
    if (V0 && V1)  pick = 1 - m_last;
    else if (V1)   pick = 1;
    else if (V0)   pick = 0;
    else           pick = -1;
    room = !m_yv || YR;
    take = !rst && model_ok && room && (pick >= 0);
    if (rst) begin
      checkOutput("m_r0_rst", {7'b0, R0}, 8'h00);
      checkOutput("m_r1_rst", {7'b0, R1}, 8'h00);
    end else if (model_ok) begin
      e_r0 = (room && pick == 0) ? 8'h01 : 8'h00;
      e_r1 = (room && pick == 1) ? 8'h01 : 8'h00;
      checkOutput("m_yv", {7'b0, YV}, {7'b0, m_yv});
      checkOutput("m_y", Y, m_y);
      checkOutput("m_r0", {7'b0, R0}, e_r0);
      checkOutput("m_r1", {7'b0, R1}, e_r1);
      if (pick < 0)
        checkOutput("m_s_idle", {7'b0, S}, 8'(m_last));
      else if (take)
        checkOutput("m_s_grant", {7'b0, S}, 8'(pick));
    end
    if (rst) begin
      m_y      = '0;
      m_yv     = 1'b0;
      m_last   = 1;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (take) begin
        m_y    = (pick == 1) ? D1 : D0;
        m_yv   = 1'b1;
        m_last = pick;
      end else if (m_yv && YR) begin
        m_yv = 1'b0;
      end
    end
  end

  // Directed scenarios with literal expectations, then random traffic.
  initial begin
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = 8'hA5;
    exp_seq[1] = 8'h3C;
    exp_seq[2] = 8'hA5;
    exp_seq[3] = 8'h3C;

    // Reset held for two cycles while both sources request.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
    checkOutput("rst_r0", {7'b0, R0}, 8'h00);
    checkOutput("rst_r1", {7'b0, R1}, 8'h00);
    tick();
    tick();
    checkOutput("rst_yv", {7'b0, YV}, 8'h00);
    checkOutput("rst_y", Y, 8'h00);

    // Tie alternation. Source 0 wins first.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("tie_s", {7'b0, S}, (i % 2 == 0) ? 8'h00 : 8'h01);
      checkOutput("tie_r0", {7'b0, R0}, (i % 2 == 0) ? 8'h01 : 8'h00);
      tick();
      checkOutput("tie_y", Y, exp_seq[i]);
      checkOutput("tie_yv", {7'b0, YV}, 8'h01);
    end

    // Reset mid-stream with Y=3C: the word is discarded and D0 wins again.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
    tick();
    checkOutput("mid_yv", {7'b0, YV}, 8'h00);
    checkOutput("mid_y", Y, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
    checkOutput("mid_s", {7'b0, S}, 8'h00);
    checkOutput("mid_r0", {7'b0, R0}, 8'h01);
    tick();
    checkOutput("mid_y2", Y, 8'hA5);

    // Lone requester on source 1.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'(i), 1'b1);
      checkOutput("lone_r1", {7'b0, R1}, 8'h01);
      checkOutput("lone_r0", {7'b0, R0}, 8'h00);
      tick();
      checkOutput("lone_y", Y, 8'(i));
    end

    // Backpressure after one accept of 11.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, 8'h22, 1'b0);
      checkOutput("bp_r0", {7'b0, R0}, 8'h00);
      checkOutput("bp_r1", {7'b0, R1}, 8'h00);
      tick();
      checkOutput("bp_y", Y, 8'h11);
      checkOutput("bp_yv", {7'b0, YV}, 8'h01);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, 8'h22, 1'b1);
    checkOutput("bp_rel_s", {7'b0, S}, 8'h01);
    checkOutput("bp_rel_r1", {7'b0, R1}, 8'h01);
    tick();
    checkOutput("bp_rel_y", Y, 8'h22);
    checkOutput("bp_rel_yv", {7'b0, YV}, 8'h01);

    // Drain to empty after one accept of 7E.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h7E, 8'h00, 1'b1);
    tick();
    checkOutput("drain_yv1", {7'b0, YV}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    checkOutput("drain_yv0", {7'b0, YV}, 8'h00);
    checkOutput("drain_y", Y, 8'h7E);
    tick();
    checkOutput("drain_yv0b", {7'b0, YV}, 8'h00);

    // Random traffic with occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    8'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0));
      tick();
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
